decode_stage: RTL

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage_pkg.sv | 65 ++++++
 rtl/operand_forward.sv | 39 +++
 rtl/decode_stage.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_pkg.sv
// Shared definitions for the decode stage.
//   - MIPS-style opcode and SPECIAL funct codes recognised by the decoder.
//   - ALU operator / category codes and their bus widths, shared with the
//     execute stage.
//   - Small helpers mapping instruction fields to ALU operators.
package decode_stage_pkg;

  // Instruction field encodings
  localparam logic [5:0] OPC_SPECIAL = 6'h00;
  localparam logic [5:0] OPC_ANDI    = 6'h0C;
  localparam logic [5:0] OPC_ORI     = 6'h0D;
  localparam logic [5:0] OPC_XORI    = 6'h0E;
  localparam logic [5:0] OPC_LUI     = 6'h0F;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_SRA = 6'h03;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;

  // ALU bus widths and codes
  localparam int ALU_OP_WIDTH  = 4;
  localparam int ALU_CAT_WIDTH = 2;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_NOP = 4'd0;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_AND = 4'd1;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_OR  = 4'd2;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_XOR = 4'd3;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_NOR = 4'd4;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLL = 4'd5;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SRL = 4'd6;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SRA = 4'd7;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_LUI = 4'd8;

  localparam logic [ALU_CAT_WIDTH-1:0] ALU_CAT_NOP   = 2'd0;
  localparam logic [ALU_CAT_WIDTH-1:0] ALU_CAT_LOGIC = 2'd1;
  localparam logic [ALU_CAT_WIDTH-1:0] ALU_CAT_SHIFT = 2'd2;

  // Operator for a SPECIAL funct; unknown functs map to NOP.
  function automatic logic [ALU_OP_WIDTH-1:0] alu_op_for_funct(input logic [5:0] funct);
    case (funct)
      FN_AND:  return ALU_OP_AND;
      FN_OR:   return ALU_OP_OR;
      FN_XOR:  return ALU_OP_XOR;
      FN_NOR:  return ALU_OP_NOR;
      FN_SLL:  return ALU_OP_SLL;
      FN_SRL:  return ALU_OP_SRL;
      FN_SRA:  return ALU_OP_SRA;
      default: return ALU_OP_NOP;
    endcase
  endfunction

  // Operator for an immediate logic opcode; anything else maps to NOP.
  function automatic logic [ALU_OP_WIDTH-1:0] alu_op_for_imm(input logic [5:0] opcode);
    case (opcode)
      OPC_ANDI: return ALU_OP_AND;
      OPC_ORI:  return ALU_OP_OR;
      OPC_XORI: return ALU_OP_XOR;
      default:  return ALU_OP_NOP;
    endcase
  endfunction

endpackage

// File: rtl/operand_forward.sv
// Operand source selection for one register-file read port.
// Ports:
//   read_enable/read_addr/read_result   - this port's register-file access
//   ex_*                                - EX-stage result (loads not forwardable)
//   mem_*                               - MEM-stage result
//   operand                             - selected value (0 when port disabled)
// Priority: $0 reads as zero, then EX, then MEM, then the register file.
module operand_forward #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      read_enable,
  input  logic [REG_ADDR_WIDTH-1:0] read_addr,
  input  logic [DATA_WIDTH-1:0]     read_result,
  input  logic                      ex_write_enable,
  input  logic                      ex_is_load,
  input  logic [REG_ADDR_WIDTH-1:0] ex_write_addr,
  input  logic [DATA_WIDTH-1:0]     ex_write_data,
  input  logic                      mem_write_enable,
  input  logic [REG_ADDR_WIDTH-1:0] mem_write_addr,
  input  logic [DATA_WIDTH-1:0]     mem_write_data,
  output logic [DATA_WIDTH-1:0]     operand
);

  always_comb begin
    operand = '0;
    if (!read_enable || read_addr == '0) begin
      operand = '0;
    end else if (ex_write_enable && !ex_is_load && ex_write_addr == read_addr) begin
      // A load in EX has no data yet; the hazard logic stalls that case.
      operand = ex_write_data;
    end else if (mem_write_enable && mem_write_addr == read_addr) begin
      operand = mem_write_data;
    end else begin
      operand = read_result;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: decodes one instruction per cycle, reads the register file
// combinationally, forwards from EX/MEM, detects load-use hazards and
// registers the decoded bundle for the execute stage.
// Ports:
//   clock, reset (sync, active-high)
//   in_valid/in_ready, program_counter, instruction  - fetch side
//   read_enable1/2, read_addr1/2, read_result1/2      - register file
//   ex_*, mem_*                                       - forwarding sources
//   flush                                             - drop input and held output
//   out_valid/out_ready + decoded bundle              - execute side
//   stall_count                                       - saturating load-use stall count
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. A producer holding valid keeps its payload stable until the transfer;
// ready may depend combinationally on valid, valid never depends on ready.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                program_counter,
  input  logic [31:0]                instruction,
  output logic                       read_enable1,
  output logic [REG_ADDR_WIDTH-1:0]  read_addr1,
  output logic                       read_enable2,
  output logic [REG_ADDR_WIDTH-1:0]  read_addr2,
  input  logic [DATA_WIDTH-1:0]      read_result1,
  input  logic [DATA_WIDTH-1:0]      read_result2,
  input  logic                       ex_write_enable,
  input  logic                       ex_is_load,
  input  logic [REG_ADDR_WIDTH-1:0]  ex_write_addr,
  input  logic [DATA_WIDTH-1:0]      ex_write_data,
  input  logic                       mem_write_enable,
  input  logic [REG_ADDR_WIDTH-1:0]  mem_write_addr,
  input  logic [DATA_WIDTH-1:0]      mem_write_data,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_pc,
  output logic [ALU_OP_WIDTH-1:0]    alu_operator,
  output logic [ALU_CAT_WIDTH-1:0]   alu_category,
  output logic [DATA_WIDTH-1:0]      alu_operand1,
  output logic [DATA_WIDTH-1:0]      alu_operand2,
  output logic                       write_enable,
  output logic [REG_ADDR_WIDTH-1:0]  write_addr,
  output logic                       invalid_inst,
  output logic [STALL_CNT_WIDTH-1:0] stall_count
);

  // Instruction fields
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16;

  assign opcode = instruction[31:26];
  assign rs     = instruction[25:21];
  assign rt     = instruction[20:16];
  assign rd     = instruction[15:11];
  assign shamt  = instruction[10:6];
  assign funct  = instruction[5:0];
  assign imm16  = instruction[15:0];

  // Decode
  logic                      dec_re1, dec_re2, dec_we, dec_inv;
  logic [REG_ADDR_WIDTH-1:0] dec_wa;
  logic [ALU_OP_WIDTH-1:0]   dec_op;
  logic [ALU_CAT_WIDTH-1:0]  dec_cat;
  logic [DATA_WIDTH-1:0]     dec_const1, dec_const2;

  always_comb begin
    dec_re1    = 1'b0;
    dec_re2    = 1'b0;
    dec_we     = 1'b0;
    dec_inv    = 1'b0;
    dec_wa     = '0;
    dec_op     = ALU_OP_NOP;
    dec_cat    = ALU_CAT_NOP;
    dec_const1 = '0;
    dec_const2 = '0;
    // The all-zero word is the canonical NOP (it would otherwise be SLL $0).
    if (instruction != 32'h0) begin
      case (opcode)
        OPC_SPECIAL: begin
          case (funct)
            FN_AND, FN_OR, FN_XOR, FN_NOR: begin
              dec_re1 = 1'b1;
              dec_re2 = 1'b1;
              dec_we  = 1'b1;
              dec_wa  = REG_ADDR_WIDTH'(rd);
              dec_op  = alu_op_for_funct(funct);
              dec_cat = ALU_CAT_LOGIC;
            end
            FN_SLL, FN_SRL, FN_SRA: begin
              // Shift amount rides on operand1, the shifted value on operand2.
              dec_re2    = 1'b1;
              dec_we     = 1'b1;
              dec_wa     = REG_ADDR_WIDTH'(rd);
              dec_op     = alu_op_for_funct(funct);
              dec_cat    = ALU_CAT_SHIFT;
              dec_const1 = DATA_WIDTH'(shamt);
            end
            default: dec_inv = 1'b1;
          endcase
        end
        OPC_ANDI, OPC_ORI, OPC_XORI: begin
          dec_re1    = 1'b1;
          dec_we     = 1'b1;
          dec_wa     = REG_ADDR_WIDTH'(rt);
          dec_op     = alu_op_for_imm(opcode);
          dec_cat    = ALU_CAT_LOGIC;
          dec_const2 = DATA_WIDTH'(imm16);
        end
        OPC_LUI: begin
          dec_we     = 1'b1;
          dec_wa     = REG_ADDR_WIDTH'(rt);
          dec_op     = ALU_OP_LUI;
          dec_cat    = ALU_CAT_LOGIC;
          dec_const2 = DATA_WIDTH'({imm16, 16'h0000});
        end
        default: dec_inv = 1'b1;
      endcase
    end
  end

  // Register-file read ports; reset silences them so no hazard or read
  // activity leaks out while the pipeline is being cleared.
  logic re1, re2;
  assign re1          = dec_re1 & ~reset;
  assign re2          = dec_re2 & ~reset;
  assign read_enable1 = re1;
  assign read_enable2 = re2;
  assign read_addr1   = re1 ? REG_ADDR_WIDTH'(rs) : '0;
  assign read_addr2   = re2 ? REG_ADDR_WIDTH'(rt) : '0;

  logic [DATA_WIDTH-1:0] fwd_operand1, fwd_operand2;

  operand_forward #(
    .DATA_WIDTH    (DATA_WIDTH),
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_fwd1 (
    .read_enable     (re1),
    .read_addr       (read_addr1),
    .read_result     (read_result1),
    .ex_write_enable (ex_write_enable),
    .ex_is_load      (ex_is_load),
    .ex_write_addr   (ex_write_addr),
    .ex_write_data   (ex_write_data),
    .mem_write_enable(mem_write_enable),
    .mem_write_addr  (mem_write_addr),
    .mem_write_data  (mem_write_data),
    .operand         (fwd_operand1)
  );

  operand_forward #(
    .DATA_WIDTH    (DATA_WIDTH),
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_fwd2 (
    .read_enable     (re2),
    .read_addr       (read_addr2),
    .read_result     (read_result2),
    .ex_write_enable (ex_write_enable),
    .ex_is_load      (ex_is_load),
    .ex_write_addr   (ex_write_addr),
    .ex_write_data   (ex_write_data),
    .mem_write_enable(mem_write_enable),
    .mem_write_addr  (mem_write_addr),
    .mem_write_data  (mem_write_data),
    .operand         (fwd_operand2)
  );

  logic [DATA_WIDTH-1:0] dec_operand1, dec_operand2;
  assign dec_operand1 = re1 ? fwd_operand1 : dec_const1;
  assign dec_operand2 = re2 ? fwd_operand2 : dec_const2;

  // Load-use hazard: the EX load result is not available for forwarding yet.
  logic hazard;
  assign hazard = in_valid && ex_is_load && ex_write_enable && (ex_write_addr != '0) &&
                  ((re1 && read_addr1 == ex_write_addr) || (re2 && read_addr2 == ex_write_addr));

  // Output register
  logic                       out_valid_q, out_valid_d;
  logic [31:0]                out_pc_q, out_pc_d;
  logic [ALU_OP_WIDTH-1:0]    alu_operator_q, alu_operator_d;
  logic [ALU_CAT_WIDTH-1:0]   alu_category_q, alu_category_d;
  logic [DATA_WIDTH-1:0]      alu_operand1_q, alu_operand1_d;
  logic [DATA_WIDTH-1:0]      alu_operand2_q, alu_operand2_d;
  logic                       write_enable_q, write_enable_d;
  logic [REG_ADDR_WIDTH-1:0]  write_addr_q, write_addr_d;
  logic                       invalid_inst_q, invalid_inst_d;
  logic [STALL_CNT_WIDTH-1:0] stall_count_q, stall_count_d;

  logic advance, load_inst, load_bubble;
  assign advance     = out_ready || !out_valid_q;
  assign load_inst   = !flush && advance && in_valid && !hazard;
  // Flush discards the held bundle even when downstream is stalled.
  assign load_bubble = flush || (advance && !load_inst);
  assign in_ready    = !reset && !flush && advance && !hazard;

  always_comb begin
    out_valid_d    = out_valid_q;
    out_pc_d       = out_pc_q;
    alu_operator_d = alu_operator_q;
    alu_category_d = alu_category_q;
    alu_operand1_d = alu_operand1_q;
    alu_operand2_d = alu_operand2_q;
    write_enable_d = write_enable_q;
    write_addr_d   = write_addr_q;
    invalid_inst_d = invalid_inst_q;
    if (load_inst) begin
      out_valid_d    = 1'b1;
      out_pc_d       = program_counter;
      alu_operator_d = dec_op;
      alu_category_d = dec_cat;
      alu_operand1_d = dec_operand1;
      alu_operand2_d = dec_operand2;
      write_enable_d = dec_we;
      write_addr_d   = dec_wa;
      invalid_inst_d = dec_inv;
    end else if (load_bubble) begin
      out_valid_d    = 1'b0;
      out_pc_d       = '0;
      alu_operator_d = ALU_OP_NOP;
      alu_category_d = ALU_CAT_NOP;
      alu_operand1_d = '0;
      alu_operand2_d = '0;
      write_enable_d = 1'b0;
      write_addr_d   = '0;
      invalid_inst_d = 1'b0;
    end
    stall_count_d = stall_count_q;
    if (hazard && stall_count_q != '1) begin
      stall_count_d = stall_count_q + STALL_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q    <= 1'b0;
      out_pc_q       <= '0;
      alu_operator_q <= ALU_OP_NOP;
      alu_category_q <= ALU_CAT_NOP;
      alu_operand1_q <= '0;
      alu_operand2_q <= '0;
      write_enable_q <= 1'b0;
      write_addr_q   <= '0;
      invalid_inst_q <= 1'b0;
      stall_count_q  <= '0;
    end else begin
      out_valid_q    <= out_valid_d;
      out_pc_q       <= out_pc_d;
      alu_operator_q <= alu_operator_d;
      alu_category_q <= alu_category_d;
      alu_operand1_q <= alu_operand1_d;
      alu_operand2_q <= alu_operand2_d;
      write_enable_q <= write_enable_d;
      write_addr_q   <= write_addr_d;
      invalid_inst_q <= invalid_inst_d;
      stall_count_q  <= stall_count_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_pc       = out_pc_q;
  assign alu_operator = alu_operator_q;
  assign alu_category = alu_category_q;
  assign alu_operand1 = alu_operand1_q;
  assign alu_operand2 = alu_operand2_q;
  assign write_enable = write_enable_q;
  assign write_addr   = write_addr_q;
  assign invalid_inst = invalid_inst_q;
  assign stall_count  = stall_count_q;

endmodule
